// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN MLP host loader.
// Holds the command byte codes, FSM state encoding, payload target
// selector and layer geometry (neuron count, nibble width).
package bnn_pkg;

  localparam int unsigned NEURONS = 4;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned OPW     = NEURONS * NIB_W;

  localparam logic [7:0] CMD_WR_W  = 8'h01;
  localparam logic [7:0] CMD_WR_B  = 8'h02;
  localparam logic [7:0] CMD_WR_IN = 8'h03;
  localparam logic [7:0] CMD_RUN   = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_RUN,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    TGT_W,
    TGT_B,
    TGT_IN
  } target_t;

  // Number of payload bytes that follow a write command.
  function automatic logic [1:0] payload_len(input target_t t);
    logic [1:0] len;
    len = 2'd2;
    if (t == TGT_IN) len = 2'd1;
    return len;
  endfunction

endpackage

// File: rtl/bnn_mlp_host_loader.sv
// Host-side front end for the 4-neuron binary MLP layer.
// Decodes a byte-stream command protocol, holds the operand registers that
// feed the layer, runs a triggered evaluation and returns the result byte.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready: inbound command/payload bytes
//   tx_data/tx_valid/tx_ready: outbound response byte
//   mlp_input/weights/bias   : operand registers driving the layer
//   mlp_result               : combinational layer result
//   trigger                  : scope trigger, high during evaluation
//   busy                     : high whenever the FSM is not idle
module bnn_mlp_host_loader
  import bnn_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES = 8,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [NIB_W-1:0]    mlp_input,
  output logic [OPW-1:0]      mlp_weights,
  output logic [OPW-1:0]      mlp_bias,
  input  logic [NIB_W-1:0]    mlp_result,
  output logic                trigger,
  output logic                busy
);

  localparam int unsigned TCW = $clog2(TRIG_CYCLES + 1);
  localparam logic [TCW-1:0] TRIG_LAST = TCW'(TRIG_CYCLES - 1);

  state_t           state, state_n;
  target_t          target;
  logic [1:0]       byte_cnt;
  logic [1:0]       byte_cnt_sat;
  logic [OPW-1:0]   stage;
  logic [OPW-1:0]   stage_n;
  logic [TCW-1:0]   trig_cnt;
  logic             rx_fire;
  logic             last_byte;
  logic             run_done;

  // Handshake, status and next-state logic.
  always_comb begin
    rx_ready     = 1'b0;
    tx_valid     = 1'b0;
    trigger      = 1'b0;
    busy         = (state != ST_IDLE);
    state_n      = state;
    byte_cnt_sat = (byte_cnt == 2'd3) ? 2'd3 : byte_cnt + 2'd1;
    last_byte    = 1'b0;
    run_done     = 1'b0;
    stage_n      = stage;

    case (state)
      ST_IDLE:    rx_ready = ~rst;
      ST_PAYLOAD: rx_ready = ~rst;
      ST_RUN:     trigger  = 1'b1;
      ST_RESP:    tx_valid = 1'b1;
      default:    ;
    endcase

    rx_fire = rx_valid & rx_ready;

    // Two-byte payloads arrive MSB first; the first byte lands in the
    // upper half, everything else in the lower half.
    if (byte_cnt == 2'd0 && payload_len(target) == 2'd2)
      stage_n[15:8] = rx_data;
    else
      stage_n[7:0]  = rx_data;

    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_WR_W, CMD_WR_B, CMD_WR_IN: state_n = ST_PAYLOAD;
            CMD_RUN:                       state_n = ST_RUN;
            default:                       state_n = ST_RESP;
          endcase
        end
      end
      ST_PAYLOAD: begin
        last_byte = rx_fire && (byte_cnt_sat == payload_len(target));
        if (last_byte) state_n = ST_IDLE;
      end
      ST_RUN: begin
        run_done = (trig_cnt == TRIG_LAST);
        if (run_done) state_n = ST_RESP;
      end
      ST_RESP: begin
        if (tx_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Operand registers, staging, counters and response byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      target      <= TGT_W;
      byte_cnt    <= '0;
      stage       <= '0;
      trig_cnt    <= '0;
      tx_data     <= '0;
      mlp_input   <= '0;
      mlp_weights <= '0;
      mlp_bias    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            byte_cnt <= '0;
            trig_cnt <= '0;
            case (rx_data)
              CMD_WR_W:  target <= TGT_W;
              CMD_WR_B:  target <= TGT_B;
              CMD_WR_IN: target <= TGT_IN;
              CMD_RUN:   ;
              default:   tx_data <= ERR_BYTE;
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (rx_fire) begin
            stage    <= stage_n;
            byte_cnt <= byte_cnt_sat;
            // Commit uses the merged staging value so the target updates
            // atomically on the edge that accepts the final byte.
            if (last_byte) begin
              case (target)
                TGT_W:   mlp_weights <= stage_n;
                TGT_B:   mlp_bias    <= stage_n;
                TGT_IN:  mlp_input   <= stage_n[NIB_W-1:0];
                default: ;
              endcase
            end
          end
        end
        ST_RUN: begin
          if (run_done) tx_data <= {4'h0, mlp_result};
          else          trig_cnt <= trig_cnt + TCW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
